// File: rtl/adc_tlv2541_reader_pkg.sv
// Shared constants and FSM encoding for the TLV2541 serial ADC reader.
package adc_tlv2541_reader_pkg;

    localparam int CNT_W     = 16;
    localparam int FRAME_LEN = 16;

    typedef logic [CNT_W-1:0] cnt_t;

    // Phase boundaries within one conversion frame, in period-counter ticks.
    localparam cnt_t SETUP_END = 16'd1;
    localparam cnt_t SHIFT_END = 16'd33;
    localparam cnt_t HOLD_CNT  = 16'd34;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        WAIT
    } state_t;

endpackage

// File: rtl/ClkDiv.sv
// Team clock divider: free-running 0..PERIOD-1 counter, held at 0 while run is low.
module ClkDiv
    import adc_tlv2541_reader_pkg::*;
#(
    parameter int unsigned PERIOD = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output cnt_t cnt
);

    cnt_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (run) cnt_d = (cnt_q == cnt_t'(PERIOD - 1)) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/adc_tlv2541_reader.sv
// Periodic TLV2541 reader: one 16-SCLK frame per SAMPLE_PERIOD clocks, result
// strobed out with data_valid. All outputs registered; SCLK runs at clk/2.
module adc_tlv2541_reader
    import adc_tlv2541_reader_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 40,
    parameter int unsigned DATA_BITS     = 12
) (
    input  logic                 clk_20M,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 SDO,
    output logic                 CS_N,
    output logic                 SCLK,
    output logic [DATA_BITS-1:0] adc_data,
    output logic                 data_valid,
    output logic                 busy
);

    if (SAMPLE_PERIOD < 40 || SAMPLE_PERIOD > 65535 || DATA_BITS == 0 || DATA_BITS > FRAME_LEN) begin : g_bad_params
        $error("adc_tlv2541_reader: illegal SAMPLE_PERIOD/DATA_BITS");
    end

    localparam cnt_t LAST_CNT = cnt_t'(SAMPLE_PERIOD - 1);
    localparam cnt_t DV_CNT   = HOLD_CNT + 16'd1;

    state_t                 state_q, state_d;
    logic                   cs_n_q, cs_n_d;
    logic                   sclk_q, sclk_d;
    logic                   busy_q, busy_d;
    logic                   dv_q, dv_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [FRAME_LEN-1:0]   shift_q, shift_d;
    logic                   run;
    cnt_t                   cnt;

    assign run = (state_q != IDLE);

    ClkDiv #(.PERIOD(SAMPLE_PERIOD)) u_clkdiv (
        .clk   (clk_20M),
        .rst_n (rst_n),
        .run   (run),
        .cnt   (cnt)
    );

    // Outputs are registered, so each branch decides what the *next* cnt value shows.
    always_comb begin
        state_d = state_q;
        cs_n_d  = cs_n_q;
        busy_d  = busy_q;
        data_d  = data_q;
        shift_d = shift_q;
        sclk_d  = 1'b0;
        dv_d    = 1'b0;
        case (state_q)
            IDLE: if (en) begin
                state_d = SETUP;
                cs_n_d  = 1'b0;
                busy_d  = 1'b1;
            end
            SETUP: if (cnt == SETUP_END) begin
                state_d = SHIFT;
                sclk_d  = 1'b1;
            end
            SHIFT: begin
                // Sample on the edge that drops SCLK, i.e. while SCLK is high.
                if (!cnt[0])                shift_d = {shift_q[FRAME_LEN-2:0], SDO};
                else if (cnt != SHIFT_END)  sclk_d  = 1'b1;
                if (cnt == SHIFT_END) begin
                    state_d = HOLD;
                    cs_n_d  = 1'b1;
                end
            end
            HOLD: begin
                state_d = WAIT;
                busy_d  = 1'b0;
                data_d  = shift_q[FRAME_LEN-1 -: DATA_BITS];
            end
            WAIT: begin
                dv_d = (cnt == DV_CNT);
                if (cnt == LAST_CNT) begin
                    if (en) begin
                        state_d = SETUP;
                        cs_n_d  = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_20M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            busy_q  <= 1'b0;
            dv_q    <= 1'b0;
            data_q  <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            busy_q  <= busy_d;
            dv_q    <= dv_d;
            data_q  <= data_d;
            shift_q <= shift_d;
        end
    end

    assign CS_N       = cs_n_q;
    assign SCLK       = sclk_q;
    assign busy       = busy_q;
    assign data_valid = dv_q;
    assign adc_data   = data_q;

endmodule

// File: tb/tb_adc_tlv2541_reader.sv
// Bench for adc_tlv2541_reader: ADC model + scoreboard for a 40-clock and a 1000-clock instance.
module tb_adc_tlv2541_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en[2];
    logic        sdo[2];
    logic        cs_n[2], sclk[2], dv[2], busy[2];
    logic [11:0] dat[2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [15:0] wq[2][$];
    logic [11:0] expq[2][$];
    int          dvq[2][$];

    always #25 clk = ~clk;

    adc_tlv2541_reader #(.SAMPLE_PERIOD(40), .DATA_BITS(12)) dut (
        .clk_20M(clk), .rst_n(rst_n), .en(en[0]), .SDO(sdo[0]), .CS_N(cs_n[0]),
        .SCLK(sclk[0]), .adc_data(dat[0]), .data_valid(dv[0]), .busy(busy[0])
    );

    adc_tlv2541_reader #(.SAMPLE_PERIOD(1000), .DATA_BITS(12)) dut_l (
        .clk_20M(clk), .rst_n(rst_n), .en(en[1]), .SDO(sdo[1]), .CS_N(cs_n[1]),
        .SCLK(sclk[1]), .adc_data(dat[1]), .data_valid(dv[1]), .busy(busy[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ADC model + protocol checker, evaluated mid-cycle on each falling clk edge.
    initial begin : monitor
        logic        prev_cs[2], prev_sclk[2], prev_dv[2], in_frame[2];
        int          falls[2], rises[2], low_len[2];
        logic [15:0] cur_word[2];
        logic [15:0] w;
        for (int d = 0; d < 2; d++) begin
            prev_cs[d] = 1; prev_sclk[d] = 0; prev_dv[d] = 0; in_frame[d] = 0;
            falls[d] = 0; rises[d] = 0; low_len[d] = 0; cur_word[d] = 0; sdo[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    if (cs_n[d] !== 1'b1 || sclk[d] !== 1'b0 || dv[d] !== 1'b0 || busy[d] !== 1'b0)
                        check("rst_outputs", {cs_n[d], sclk[d], dv[d], busy[d]}, 4'b1000);
                    in_frame[d] = 0; prev_cs[d] = 1; prev_sclk[d] = 0; prev_dv[d] = 0; sdo[d] = 0;
                    continue;
                end
                if (cs_n[d] && sclk[d]) check("sclk_while_cs_high", sclk[d], 0);
                check("busy", busy[d], !cs_n[d] || !prev_cs[d]);
                if (prev_cs[d] && !cs_n[d]) begin
                    cur_word[d] = (wq[d].size() > 0) ? wq[d].pop_front() : 16'($urandom);
                    falls[d] = 0; rises[d] = 0; low_len[d] = 0; in_frame[d] = 1;
                end
                if (!cs_n[d]) begin
                    low_len[d]++;
                    if (!prev_sclk[d] && sclk[d]) rises[d]++;
                    if (prev_sclk[d] && !sclk[d]) falls[d]++;
                end
                if (!prev_cs[d] && cs_n[d] && in_frame[d]) begin
                    check("sclk_rises_per_frame", rises[d], 16);
                    check("cs_low_len", low_len[d], 34);
                    expq[d].push_back(cur_word[d][15:4]);
                    in_frame[d] = 0;
                end
                if (dv[d]) begin
                    check("dv_one_cycle", prev_dv[d], 0);
                    if (expq[d].size() == 0) check("dv_expected", 0, 1);
                    else                     check("sb_data", dat[d], expq[d].pop_front());
                    dvq[d].push_back(cyc);
                end
                // Real bit only where the DUT should sample; noise elsewhere.
                w = cur_word[d] << falls[d];
                sdo[d] = (!cs_n[d] && sclk[d]) ? w[15] : 1'($urandom);
                prev_cs[d] = cs_n[d]; prev_sclk[d] = sclk[d]; prev_dv[d] = dv[d];
            end
        end
    end

    task automatic wait_dv(input int d, input int budget, output int c, output bit ok);
        int n0;
        n0 = dvq[d].size();
        ok = 0;
        c = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (dvq[d].size() > n0) begin
                c = dvq[d][n0];
                ok = 1;
                break;
            end
        end
        check("dv_timeout", ok, 1);
    endtask

    typedef struct {
        logic [15:0] word;
        logic [11:0] exp;
    } vec_t;

    initial begin
        vec_t tbl[7];
        int   t0, c, prev_c, n0, low;
        bit   ok;
        tbl[0] = '{16'hABC0, 12'hABC};
        tbl[1] = '{16'hABC0, 12'hABC};
        tbl[2] = '{16'hFFFF, 12'hFFF};
        tbl[3] = '{16'h0000, 12'h000};
        tbl[4] = '{16'h1234, 12'h123};
        tbl[5] = '{16'h800F, 12'h800};
        tbl[6] = '{16'h7FF1, 12'h7FF};

        rst_n = 1; en[0] = 0; en[1] = 0;
        #2 rst_n = 0;
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_cs_n", cs_n[d], 1);
            check("rst_sclk", sclk[d], 0);
            check("rst_data", dat[d], 0);
            check("rst_dv", dv[d], 0);
            check("rst_busy", busy[d], 0);
        end
        @(posedge clk);
        #5 rst_n = 1;
        repeat (5) @(negedge clk);
        #1 check("idle_cs_n", cs_n[0], 1);

        // Table-driven frames, en held high.
        foreach (tbl[i]) wq[0].push_back(tbl[i].word);
        @(negedge clk);
        en[0] = 1;
        t0 = cyc + 1;
        prev_c = 0;
        foreach (tbl[i]) begin
            wait_dv(0, 120, c, ok);
            if (!ok) break;
            check("tbl_data", dat[0], tbl[i].exp);
            if (i == 0) check("first_latency", c - t0, 36);
            else        check("period_40", c - prev_c, 40);
            prev_c = c;
        end

        // Random frames: scoreboard compares each result to its word[15:4].
        repeat (6) begin
            wait_dv(0, 120, c, ok);
            if (!ok) break;
            check("rand_period_40", c - prev_c, 40);
            prev_c = c;
        end

        // Drop en at cnt=10 of the following frame (dv sits at cnt=36).
        repeat (14) @(negedge clk);
        en[0] = 0;
        n0 = dvq[0].size();
        wait_dv(0, 60, c, ok);
        check("en_drop_last_period", c - prev_c, 40);
        low = 0;
        repeat (200) begin
            @(negedge clk);
            #1;
            if (!cs_n[0]) low++;
        end
        check("en_drop_no_more_frames", low, 0);
        check("en_drop_dv_count", dvq[0].size() - n0, 1);

        // Reset pulse mid-frame at cnt=20.
        @(negedge clk);
        en[0] = 1;
        repeat (21) @(posedge clk);
        #5 check("pre_rst_cs_low", cs_n[0], 0);
        check("pre_rst_sclk_high", sclk[0], 1);
        rst_n = 0;
        #1;
        check("async_rst_cs_n", cs_n[0], 1);
        check("async_rst_sclk", sclk[0], 0);
        n0 = dvq[0].size();
        wq[0].push_back(16'h5A5A);
        @(posedge clk);
        #5 rst_n = 1;
        t0 = cyc + 1;
        wait_dv(0, 100, c, ok);
        check("post_rst_latency", c - t0, 36);
        check("post_rst_data", dat[0], 12'h5A5);
        check("post_rst_dv_count", dvq[0].size() - n0, 1);
        @(negedge clk);
        en[0] = 0;

        // Long-period instance.
        repeat (50) @(negedge clk);
        en[1] = 1;
        t0 = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            wait_dv(1, 1100, c, ok);
            if (!ok) break;
            if (i == 0) check("long_first_latency", c - t0, 36);
            else        check("period_1000", c - prev_c, 1000);
            prev_c = c;
        end
        @(negedge clk);
        en[1] = 0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_tlv2541_reader.md
ADC_TLV2541_READER -- requirements
Module: adc_tlv2541_reader

Interface
REQ-001 SAMPLE_PERIOD, 40, clk_20M cycles per conversion frame (40 -> 500 kSPS); legal range 40..65535.
REQ-002 DATA_BITS, 12, converter result width; the frame is always 16 SCLK periods.
REQ-003 clk_20M  input  1  system clock, 20 MHz; all logic is on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  level; 1 = run periodic conversions.
REQ-006 SDO  input  1  serial data from the ADC, MSB first.
REQ-007 CS_N  output  1  ADC chip select, active low, registered.
REQ-008 SCLK  output  1  serial clock, 10 MHz during a frame, registered (not gated from clk_20M).
REQ-009 adc_data  output  DATA_BITS  last completed conversion result.
REQ-010 data_valid  output  1  one-cycle strobe when adc_data updates.
REQ-011 busy  output  1  high from the CS_N falling cycle through the CS_N rising cycle.

Function
REQ-012 A period counter cnt SHALL run 0..SAMPLE_PERIOD-1 and wrap while the FSM is not IDLE; it SHALL be held at 0 in IDLE.
REQ-013 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD and WAIT.
REQ-014 IDLE -> SETUP when en=1; CS_N is driven low on that edge (cnt=0).
REQ-015 SETUP SHALL last 2 clocks (cnt 0..1) with SCLK=0, giving at least 100 ns CS_N-to-first-edge setup.
REQ-016 SHIFT (cnt 2..33) SHALL drive SCLK=1 on even cnt and SCLK=0 on odd cnt, giving 16 rising edges.
REQ-017 SDO SHALL be shifted into a 16-bit register, MSB first, at each odd cnt 3..33 (the edge that drives SCLK low).
REQ-018 HOLD (cnt 34) SHALL drive CS_N=1, load adc_data with shift[15:16-DATA_BITS], and assert data_valid on the next cycle for exactly 1 clock.
REQ-019 WAIT (cnt 35..SAMPLE_PERIOD-1) SHALL keep CS_N=1 and SCLK=0; at wrap, go to SETUP if en=1, otherwise to IDLE.
REQ-020 Deasserting en mid-frame SHALL NOT truncate the frame: the current frame completes and data_valid still fires.
REQ-021 The 16-DATA_BITS trailing bits SHALL be discarded.
REQ-022 Frame-to-frame latency SHALL be exactly SAMPLE_PERIOD clocks; the first data_valid after en rises SHALL occur 36 clocks after the IDLE->SETUP edge.
REQ-023 SCLK SHALL be 0 whenever CS_N=1.

Reset
REQ-024 While rst_n=0: CS_N=1, SCLK=0, adc_data=0, data_valid=0, busy=0, cnt=0, FSM=IDLE, shift register=0.
REQ-025 A reset asserted mid-frame SHALL raise CS_N and clear SCLK immediately (asynchronously) and discard the partial frame; no data_valid is issued.
REQ-026 After rst_n releases, the first frame SHALL begin on the first clock with en=1.

Structure
REQ-027 The shared package SHALL hold the FSM state encoding, FRAME_LEN=16, and the phase constants SETUP_END=1, SHIFT_END=33 and HOLD_CNT=34.
REQ-028 The period counter SHALL be the existing team clock-divider sub-module (ClkDiv) instantiated with SAMPLE_PERIOD; the FSM and shifter SHALL live in this module.
REQ-029 Elaboration SHALL fail if SAMPLE_PERIOD < 40 or DATA_BITS > 16.

Verification
REQ-030 ADC model returns 0xABC0, en held high, SAMPLE_PERIOD=40 -> adc_data=0xABC, data_valid every 40 clocks, 16 SCLK rises per CS_N low window.
REQ-031 Model returns 0xFFFF, then 0x0000 -> adc_data=0xFFF, then 0x000; no bit leaks between frames.
REQ-032 en dropped at cnt=10 -> frame completes, one data_valid fires, CS_N stays 1 and no SCLK edges occur afterwards.
REQ-033 rst_n pulsed low at cnt=20 -> CS_N=1 and SCLK=0 within the same cycle, no data_valid; after release with en=1, a clean frame yields the correct value.
REQ-034 SAMPLE_PERIOD=1000 -> data_valid spacing is exactly 1000 clocks; CS_N low window is exactly 34 clocks (cnt 0..33).
REQ-035 Checker on every frame: SCLK=0 whenever CS_N=1, and SDO is sampled only on SCLK high->low transitions.
